lusdosnios_onchip_mem_arbiter: RTL
==================================

LUSDOSNIOS_ONCHIP_MEM_ARBITER -- requirements
Module: lusdosnios_onchip_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: word-address width; the memory holds 1024 words.
REQ-002 SHALL have parameter DATA_W, default 32: data width.
REQ-003 SHALL have parameter BE_W, default 4: byteenable width, equal to DATA_W/8.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port mI_address, input, ADDR_W bits, for I in {0,1}: requester word address.
REQ-007 SHALL have port mI_byteenable, input, BE_W bits: requester byte lanes for writes.
REQ-008 SHALL have port mI_read, input, 1 bit: read request.
REQ-009 SHALL have port mI_write, input, 1 bit: write request.
REQ-010 SHALL have port mI_writedata, input, DATA_W bits: write data.
REQ-011 SHALL have port mI_waitrequest, output, 1 bit: high while the request is not accepted.
REQ-012 SHALL have port mI_readdata, output, DATA_W bits: read return data.
REQ-013 SHALL have port mI_readdatavalid, output, 1 bit: mI_readdata is valid this cycle.
REQ-014 SHALL have port mem_address, output, ADDR_W bits: memory port address.
REQ-015 SHALL have port mem_byteenable, output, BE_W bits: memory byte lanes.
REQ-016 SHALL have port mem_chipselect, output, 1 bit: memory access this cycle.
REQ-017 SHALL have port mem_write, output, 1 bit: memory write strobe.
REQ-018 SHALL have port mem_writedata, output, DATA_W bits: memory write data.
REQ-019 SHALL have port mem_clken, output, 1 bit: memory clock enable.
REQ-020 SHALL have port mem_readdata, input, DATA_W bits: memory read data, valid one clk after the address is sampled.

Function
REQ-021 SHALL treat mI as requesting when mI_read or mI_write is high; mI_read and mI_write both high SHALL be handled as a write with no readdatavalid.
REQ-022 SHALL grant at most one requester per cycle; the grant is combinational from the current requests and the priority pointer.
REQ-023 SHALL grant the sole requester when only one requests; when both request, SHALL grant the requester named by the priority pointer.
REQ-024 SHALL update the priority pointer on every grant to point at the non-granted requester; with no grant, the pointer holds.
REQ-025 Granted requester SHALL see mI_waitrequest=0 in the grant cycle; every requester not granted SHALL see mI_waitrequest=1; with no request, both waitrequests SHALL be 0.
REQ-026 In a grant cycle SHALL drive mem_chipselect=1 and SHALL drive mem_address, mem_byteenable and mem_writedata from the granted requester; mem_write SHALL equal the granted requester's write. Otherwise mem_chipselect=0 and mem_write=0.
REQ-027 mem_clken SHALL be 1 except during reset, when it SHALL be 0.
REQ-028 Read latency SHALL be exactly 1 cycle: a read granted in cycle N SHALL assert mI_readdatavalid for the same requester in cycle N+1, for exactly 1 cycle, with mI_readdata = mem_readdata.
REQ-029 Back-to-back reads SHALL be fully pipelined, one grant per cycle; interleaved m0/m1 grants SHALL return data in grant order to the correct owner.
REQ-030 A granted write SHALL complete at the grant-cycle clock edge with no readdatavalid.
REQ-031 A requester that holds its request continuously SHALL be granted within 2 cycles.
REQ-032 mI_readdata SHALL be don't-care when mI_readdatavalid=0; 0 is the recommended value.

Reset
REQ-033 While reset=1 at a clock edge: priority pointer SHALL become m0, the read-return pipeline SHALL clear, and both readdatavalid outputs SHALL be 0 in the following cycle.
REQ-034 While reset is high: both waitrequests=1, mem_chipselect=0, mem_write=0, mem_clken=0, and no grant.
REQ-035 A read granted in the cycle before reset asserts SHALL NOT produce readdatavalid.

Verification
REQ-036 m0 alone reads addr 0x005 holding 0xDEADBEEF -> m0_waitrequest=0 in cycle N, m0_readdatavalid=1 with 0xDEADBEEF in cycle N+1, m1 outputs idle.
REQ-037 m0 and m1 both read continuously from reset release -> grants go m0,m1,m0,m1; each readdatavalid arrives one cycle after its owner's grant.
REQ-038 m1 writes 0x12345678, byteenable 0x3, to 0x3FF, then m0 reads 0x3FF (old value 0) -> m0 gets 0x00005678.
REQ-039 m0 holds a write while m1 issues 3 reads -> every request granted within 2 cycles; write completes; 3 readdatavalid pulses go only to m1.
REQ-040 Reset asserted the cycle after an m1 read grant -> no m1_readdatavalid; after release, a simultaneous request is granted to m0 first.

Source files
------------

// File: rtl/lusdosnios_onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip memory.
// Grants are combinational, and read data returns one cycle after the grant to its owner.
module lusdosnios_onchip_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic req0, req1;
  logic grant0, grant1;
  logic prio_q, prio_d;
  logic rvalid0_q, rvalid0_d;
  logic rvalid1_q, rvalid1_d;

  // prio_q = 0 means m0 wins a tie; it always flips toward the loser after a grant.
  always_comb begin
    req0   = m0_read | m0_write;
    req1   = m1_read | m1_write;
    grant0 = ~reset & req0 & (~req1 | ~prio_q);
    grant1 = ~reset & req1 & (~req0 | prio_q);

    prio_d = prio_q;
    if (grant0) begin
      prio_d = 1'b1;
    end else if (grant1) begin
      prio_d = 1'b0;
    end

    // A read+write request is treated as a write, so it never returns data.
    rvalid0_d = grant0 & m0_read & ~m0_write;
    rvalid1_d = grant1 & m1_read & ~m1_write;
  end

  always_comb begin
    m0_waitrequest = reset | (req0 & ~grant0);
    m1_waitrequest = reset | (req1 & ~grant1);

    mem_chipselect = grant0 | grant1;
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    mem_write      = grant0 & m0_write;
    if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end
    mem_clken = ~reset;

    // Gating with reset drops a read that was granted just before reset asserted.
    m0_readdatavalid = rvalid0_q & ~reset;
    m1_readdatavalid = rvalid1_q & ~reset;
    m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
    m1_readdata      = m1_readdatavalid ? mem_readdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

endmodule
